param_rx_frame_writer: RTL and testbench
========================================

Name: param_rx_frame_writer

Overview:
Receive-side framer that sits directly upstream of the parameter comms subsystem. It takes a byte stream from the serial comms front end, hunts for parameter frames, checks the CRC-16, and packs the payload little-endian into the parameter RX RAM through its second port (s2). On each good frame it latches the length and page and holds an interrupt level to the CPU (parameter GPIO in_port) until the CPU acknowledges (GPIO out_port).

Parameters:
ADDR_W, 11, RX RAM word-address width (2048 x 32-bit words)
MAX_LEN, 8192, maximum payload length in bytes; must be <= 4*2**ADDR_W
TIMEOUT_CYCLES, 100000, maximum inter-byte gap inside a frame; 0 disables the timeout
SOF_BYTE, 8'hA5, start-of-frame marker

Ports:
clk_ext_ram_clk  in  1  single clock, shared with RX RAM port s2
reset_ext_ram_reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready
ram_address  out  ADDR_W  to parameter_rx_ram_s2_address
ram_chipselect  out  1  to s2_chipselect
ram_clken  out  1  to s2_clken; tied high after reset
ram_write  out  1  to s2_write; one-cycle pulse
ram_writedata  out  32  to s2_writedata
ram_byteenable  out  4  to s2_byteenable
frame_irq  out  1  level, good frame waiting; to parameter GPIO in_port
frame_ack  in  1  CPU acknowledge; from parameter GPIO out_port
frame_length  out  16  payload byte count of the last good frame
frame_page  out  8  page byte of the last good frame
crc_err  out  1  one-cycle pulse, CRC mismatch
len_err  out  1  one-cycle pulse, length is 0 or greater than MAX_LEN
timeout_err  out  1  one-cycle pulse, inter-byte timeout

Behaviour:
- Reset: every output is 0, including rx_ready and ram_clken. The state machine returns to HUNT and the counters and CRC clear. Reset asserted mid-frame discards the frame; RAM words already written are not restored.
- Frame format: SOF, PAGE, LEN_HI, LEN_LO, N payload bytes, CRC_HI, CRC_LO.
- CRC: CRC-16/CCITT-FALSE (polynomial 0x1021, init 0xFFFF, no reflection, no xorout), computed over the payload bytes only, updated one byte per accepted byte.
- States:
  - HUNT: discards any byte other than SOF; SOF moves to PAGE.
  - PAGE, then LEN_HI, then LEN_LO, one byte each.
  - At LEN_LO: if the assembled length is 0 or > MAX_LEN, pulse len_err and go to HUNT; otherwise go to PAYLOAD.
  - PAYLOAD: accepts exactly N bytes, then CRC_HI, then CRC_LO.
  - After CRC_LO: on a match, latch frame_length and frame_page, set frame_irq, go to DONE. On a mismatch, pulse crc_err and go to HUNT.
  - DONE: waits for frame_ack.
- rx_ready is 1 in every state except DONE and reset.
- Packing: payload byte k goes to word address k>>2, lane k[1:0] (lane 0 = bits 7:0).
  - A write is issued the cycle after lane 3 is filled, or the cycle after the last payload byte.
  - The write is a one-cycle pulse: ram_write=1, ram_chipselect=1, byteenable = lanes filled, unfilled writedata lanes = 0.
  - The word assembler clears after each write.
  - Address wraps modulo 2**ADDR_W; this cannot occur when MAX_LEN is legal.
- The payload is written before the CRC is checked; a bad frame leaves partial data in RAM and does not raise frame_irq.
- frame_ack: sampled high in DONE clears frame_irq the next cycle and returns to HUNT. frame_ack is ignored in every other state. frame_length and frame_page hold until the next good frame.
- Timeout: the gap counter clears on each accepted byte. In PAGE through CRC_LO, reaching TIMEOUT_CYCLES-1 idle cycles pulses timeout_err and returns to HUNT. No timeout applies in HUNT or DONE.
- Simultaneous events:
  - An error pulse and the state change occur in the same cycle.
  - A pending partial-word write still completes when timeout_err fires.

Optional Feature:
PARAM_RX_CRC_CHECK_EN
- Defined: CRC is computed and compared as described above, and crc_err is active.
- Undefined: the CRC logic is not built. CRC_HI and CRC_LO are still consumed, every length-valid frame is treated as good, and crc_err is tied to 0.

Test Plan:
- Reset, then send A5 03 00 09 31 32 33 34 35 36 37 38 39 29 B1 ->
  - writes {0,0x34333231,F}, {1,0x38373635,F}, {2,0x00000039,1};
  - frame_irq=1, frame_length=9, frame_page=0x03, rx_ready=0.
- Pulse frame_ack for 1 cycle -> frame_irq=0 the next cycle, rx_ready=1; frame_length and frame_page unchanged.
- Same frame with CRC bytes 29 B2 -> crc_err pulses once, frame_irq stays 0, state returns to HUNT (with the macro undefined: frame_irq=1 instead).
- Header length 00 00, then a separate header with length 0x2001 -> len_err pulses once each, no RAM writes.
- Stall 100000 cycles after byte 34 -> word 0 written, timeout_err pulses, next SOF starts a new frame correctly.
- Garbage 00 FF 5A before SOF, and frame_ack pulsed while in HUNT -> bytes ignored, no effect; the following frame is received normally.

Source files
------------

// File: rtl/param_rx_frame_writer.sv
// rtl/param_rx_frame_writer.sv - parameter frame receiver: hunts SOF, checks CRC-16, packs payload into RX RAM s2.
// Optional CRC checking is built when PARAM_RX_CRC_CHECK_EN is defined.
module param_rx_frame_writer #(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned MAX_LEN        = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic              clk_ext_ram_clk,
  input  logic              reset_ext_ram_reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              frame_irq,
  input  logic              frame_ack,
  output logic [15:0]       frame_length,
  output logic [7:0]        frame_page,
  output logic              crc_err,
  output logic              len_err,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_HUNT, S_PAGE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CRC_HI, S_CRC_LO, S_DONE
  } state_t;

  localparam int unsigned TO_LIM = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 1;

  state_t              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                clken_q, clken_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wbe_q, wbe_d;
  logic                irq_q, irq_d;
  logic [15:0]         flen_q, flen_d;
  logic [7:0]          fpage_q, fpage_d;
  logic                len_err_q, len_err_d;
  logic                to_err_q, to_err_d;
  logic [7:0]          page_q, page_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         gap_q, gap_d;

  logic                accept;
  logic                timed;
  logic                timeout_hit;
  logic [15:0]         len_asm;
  logic                len_bad;
  logic                last_byte;
  logic                crc_ok;
  logic [1:0]          lane;
  logic [31:0]         word_wr;
  logic [3:0]          be_wr;

  assign accept    = rx_valid && rx_ready_q;
  assign timed     = (state_q != S_HUNT) && (state_q != S_DONE);
  assign len_asm   = {len_hi_q, rx_data};
  assign len_bad   = (len_asm == 16'd0) || ({16'd0, len_asm} > MAX_LEN);
  assign last_byte = (cnt_q == len_q - 16'd1);
  assign lane      = cnt_q[1:0];

  // A timeout fires on the idle cycle that brings the gap count up to TO_LIM.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0 && timed && !accept && (gap_q + 32'd1 >= TO_LIM))
      timeout_hit = 1'b1;
  end

  always_comb begin
    word_wr = word_q;
    word_wr[{lane, 3'b000} +: 8] = rx_data;
    be_wr = be_q | (4'b0001 << lane);
  end

`ifdef PARAM_RX_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q, crc_hi_d;
  logic        crc_err_q, crc_err_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign crc_ok  = ({crc_hi_q, rx_data} == crc_q);
  assign crc_err = crc_err_q;

  always_comb begin
    crc_d     = crc_q;
    crc_hi_d  = crc_hi_q;
    crc_err_d = 1'b0;
    if (accept) begin
      case (state_q)
        S_LEN_LO:  crc_d = 16'hFFFF;
        S_PAYLOAD: crc_d = crc16_byte(crc_q, rx_data);
        S_CRC_HI:  crc_hi_d = rx_data;
        S_CRC_LO:  crc_err_d = !crc_ok;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_ext_ram_clk or posedge reset_ext_ram_reset) begin
    if (reset_ext_ram_reset) begin
      crc_q     <= 16'd0;
      crc_hi_q  <= 8'd0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_hi_q  <= crc_hi_d;
      crc_err_q <= crc_err_d;
    end
  end
`else
  assign crc_ok  = 1'b1;
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge clk_ext_ram_clk or posedge reset_ext_ram_reset) begin
    if (reset_ext_ram_reset) state_q <= S_HUNT;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT:    if (accept && rx_data == SOF_BYTE) state_d = S_PAGE;
      S_PAGE:    if (accept) state_d = S_LEN_HI;
      S_LEN_HI:  if (accept) state_d = S_LEN_LO;
      S_LEN_LO:  if (accept) state_d = len_bad ? S_HUNT : S_PAYLOAD;
      S_PAYLOAD: if (accept && last_byte) state_d = S_CRC_HI;
      S_CRC_HI:  if (accept) state_d = S_CRC_LO;
      S_CRC_LO:  if (accept) state_d = crc_ok ? S_DONE : S_HUNT;
      S_DONE:    if (frame_ack) state_d = S_HUNT;
      default:   state_d = S_HUNT;
    endcase
    if (timeout_hit) state_d = S_HUNT;
  end

  always_comb begin
    rx_ready_d = (state_d != S_DONE);
    clken_d    = 1'b1;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    wbe_d      = wbe_q;
    irq_d      = irq_q;
    flen_d     = flen_q;
    fpage_d    = fpage_q;
    len_err_d  = 1'b0;
    to_err_d   = 1'b0;
    page_d     = page_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    be_d       = be_q;
    gap_d      = (accept || !timed) ? 32'd0 : gap_q + 32'd1;

    if (accept) begin
      case (state_q)
        S_PAGE:   page_d = rx_data;
        S_LEN_HI: len_hi_d = rx_data;
        S_LEN_LO: begin
          len_d     = len_asm;
          len_err_d = len_bad;
          cnt_d     = 16'd0;
          word_d    = 32'd0;
          be_d      = 4'd0;
        end
        S_PAYLOAD: begin
          cnt_d  = cnt_q + 16'd1;
          word_d = word_wr;
          be_d   = be_wr;
          if (lane == 2'd3 || last_byte) begin
            wr_d    = 1'b1;
            addr_d  = ADDR_W'(cnt_q >> 2);
            wdata_d = word_wr;
            wbe_d   = be_wr;
            word_d  = 32'd0;
            be_d    = 4'd0;
          end
        end
        S_CRC_LO: begin
          if (crc_ok) begin
            flen_d  = len_q;
            fpage_d = page_q;
            irq_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_q == S_DONE && frame_ack) irq_d = 1'b0;

    // A partially filled word is flushed so the RAM holds every byte received.
    if (timeout_hit) begin
      to_err_d = 1'b1;
      gap_d    = 32'd0;
      if (be_q != 4'd0) begin
        wr_d    = 1'b1;
        addr_d  = ADDR_W'(cnt_q >> 2);
        wdata_d = word_q;
        wbe_d   = be_q;
      end
      word_d = 32'd0;
      be_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_ext_ram_clk or posedge reset_ext_ram_reset) begin
    if (reset_ext_ram_reset) begin
      rx_ready_q <= 1'b0;
      clken_q    <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      wbe_q      <= 4'd0;
      irq_q      <= 1'b0;
      flen_q     <= 16'd0;
      fpage_q    <= 8'd0;
      len_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      page_q     <= 8'd0;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      word_q     <= 32'd0;
      be_q       <= 4'd0;
      gap_q      <= 32'd0;
    end else begin
      rx_ready_q <= rx_ready_d;
      clken_q    <= clken_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wbe_q      <= wbe_d;
      irq_q      <= irq_d;
      flen_q     <= flen_d;
      fpage_q    <= fpage_d;
      len_err_q  <= len_err_d;
      to_err_q   <= to_err_d;
      page_q     <= page_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      be_q       <= be_d;
      gap_q      <= gap_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign ram_clken      = clken_q;
  assign ram_address    = addr_q;
  assign ram_write      = wr_q;
  assign ram_chipselect = wr_q;
  assign ram_writedata  = wdata_q;
  assign ram_byteenable = wbe_q;
  assign frame_irq      = irq_q;
  assign frame_length   = flen_q;
  assign frame_page     = fpage_q;
  assign len_err        = len_err_q;
  assign timeout_err    = to_err_q;

endmodule

// File: tb/tb_param_rx_frame_writer.sv
// tb/tb_param_rx_frame_writer.sv - scoreboard bench for param_rx_frame_writer.
module tb_param_rx_frame_writer;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_clken, ram_write;
  logic [31:0]       ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              frame_irq;
  logic              frame_ack = 1'b0;
  logic [15:0]       frame_length;
  logic [7:0]        frame_page;
  logic              crc_err, len_err, timeout_err;

  param_rx_frame_writer #(.ADDR_W(ADDR_W), .MAX_LEN(8192), .TIMEOUT_CYCLES(16), .SOF_BYTE(8'hA5)) dut (
    .clk_ext_ram_clk(clk), .reset_ext_ram_reset(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .frame_irq(frame_irq), .frame_ack(frame_ack), .frame_length(frame_length),
    .frame_page(frame_page), .crc_err(crc_err), .len_err(len_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cnt_crc = 0, cnt_len = 0, cnt_to = 0;

  // Monitor: every RAM write is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (crc_err) cnt_crc++;
      if (len_err) cnt_len++;
      if (timeout_err) cnt_to++;
      if (ram_write) begin
        wr_t e;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL ram_write_unexpected: got addr=%0h data=%08h be=%0h, required no write",
                   ram_address, ram_writedata, ram_byteenable);
        end else begin
          e = exp_q.pop_front();
          if (ram_address !== e.a || ram_writedata !== e.d || ram_byteenable !== e.be ||
              ram_chipselect !== 1'b1) begin
            fails++;
            $display("FAIL ram_write: got addr=%0h data=%08h be=%0h cs=%0b, required addr=%0h data=%08h be=%0h cs=1",
                     ram_address, ram_writedata, ram_byteenable, ram_chipselect, e.a, e.d, e.be);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_wait: got rx_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] page, input logic [7:0] crc_lo);
    logic [7:0] pl [9];
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_wr(0, 32'h34333231, 4'hF);
    push_wr(1, 32'h38373635, 4'hF);
    push_wr(2, 32'h00000039, 4'h1);
    send_byte(8'hA5); send_byte(page); send_byte(8'h00); send_byte(8'h09);
    for (int i = 0; i < 9; i++) send_byte(pl[i]);
    send_byte(8'h29); send_byte(crc_lo);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic wait_timeout(input int base);
    int n;
    n = 0;
    while (cnt_to == base && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("timeout_pulse_count", cnt_to, base + 1);
    chk("timeout_rx_ready", rx_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_ram_clken", ram_clken, 0);
    chk("reset_frame_irq", frame_irq, 0);
    chk("reset_ram_write", ram_write, 0);
    chk("reset_frame_length", frame_length, 0);
    chk("reset_frame_page", frame_page, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_rx_ready", rx_ready, 1);
    chk("post_reset_ram_clken", ram_clken, 1);

    send_frame(8'h03, 8'hB1);
    chk("good_irq", frame_irq, 1);
    chk("good_length", frame_length, 9);
    chk("good_page", frame_page, 8'h03);
    chk("good_rx_ready", rx_ready, 0);
    chk("good_writes_drained", exp_q.size(), 0);

    ack_pulse();
    chk("ack_irq", frame_irq, 0);
    chk("ack_rx_ready", rx_ready, 1);
    chk("ack_length_held", frame_length, 9);
    chk("ack_page_held", frame_page, 8'h03);

    send_frame(8'h03, 8'hB2);
`ifdef PARAM_RX_CRC_CHECK_EN
    chk("badcrc_irq", frame_irq, 0);
    chk("badcrc_crc_err_count", cnt_crc, 1);
    chk("badcrc_rx_ready", rx_ready, 1);
`else
    chk("badcrc_irq_nocheck", frame_irq, 1);
    chk("badcrc_crc_err_count", cnt_crc, 0);
    ack_pulse();
    chk("badcrc_ack_irq", frame_irq, 0);
`endif
    chk("badcrc_writes_drained", exp_q.size(), 0);

    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk("len_zero_count", cnt_len, 1);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h20); send_byte(8'h01);
    @(negedge clk);
    chk("len_big_count", cnt_len, 2);
    chk("len_irq", frame_irq, 0);
    chk("len_rx_ready", rx_ready, 1);

    push_wr(0, 32'h34333231, 4'hF);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h09);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    wait_timeout(0);
    chk("timeout_full_word_written", exp_q.size(), 0);

    push_wr(0, 32'h00003231, 4'h3);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h09);
    send_byte(8'h31); send_byte(8'h32);
    wait_timeout(1);
    chk("timeout_partial_flushed", exp_q.size(), 0);
    chk("timeout_irq", frame_irq, 0);

    send_frame(8'h05, 8'hB1);
    chk("after_to_irq", frame_irq, 1);
    chk("after_to_page", frame_page, 8'h05);
    chk("after_to_length", frame_length, 9);
    ack_pulse();

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    ack_pulse();
    @(negedge clk);
    chk("garbage_irq", frame_irq, 0);
    chk("garbage_page_held", frame_page, 8'h05);
    chk("garbage_rx_ready", rx_ready, 1);
    send_frame(8'h06, 8'hB1);
    chk("post_garbage_irq", frame_irq, 1);
    chk("post_garbage_page", frame_page, 8'h06);
    chk("post_garbage_length", frame_length, 9);
    ack_pulse();

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_len_err_count", cnt_len, 2);
    chk("final_timeout_count", cnt_to, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
